// File: rtl/fdiv_srt_iter_ctrl.sv
// Sequencing controller for the radix-16 SRT fraction divider.
// Accepts an operation, runs the format-dependent number of iterations, then a
// single post-process cycle, and holds the result handshake until it is taken.
// Optional performance counters are enabled with FDIV_SRT_ITER_CTRL_PERF_EN.
module fdiv_srt_iter_ctrl #(
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned FIRST_BITS = 3,
    parameter int unsigned ITER_BITS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [1:0]       fp_format_i,
    input  logic             fraca_lt_fracb_i,
    input  logic             special_case_i,
    input  logic             flush_i,
    output logic             iter_start_o,
    output logic             iter_vld_o,
    output logic             iter_end_o,
    output logic [CNT_W-1:0] iter_counter_o,
    output logic [CNT_W-1:0] quot_bits_calculated_o,
    output logic [3:0]       quot_discard_num_one_hot_o,
    output logic             post_vld_o,
    output logic             finish_valid_o,
    input  logic             finish_ready_i
`ifdef FDIV_SRT_ITER_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_ops_o,
    output logic [31:0]      perf_cycles_o
`endif
);

    typedef enum logic [1:0] {StIdle, StIter, StPost, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_q, last_d;   // index of the final iteration (K-1)
    logic [3:0]       disc_q, disc_d;
    logic [CNT_W-1:0] lut_last;
    logic [3:0]       lut_disc;
    logic             accept;
    logic             finish_hs;

    // Iteration count and discard amount for the incoming operation.
    // Reserved format 3 falls into the f64 entry.
    always_comb begin
        lut_last = CNT_W'(13);
        lut_disc = 4'b0001;
        case (fp_format_i)
            2'd0: begin
                lut_last = CNT_W'(3);
                lut_disc = fraca_lt_fracb_i ? 4'b1000 : 4'b0100;
            end
            2'd1: begin
                lut_last = CNT_W'(6);
                lut_disc = fraca_lt_fracb_i ? 4'b0100 : 4'b0010;
            end
            default: begin
                lut_last = CNT_W'(13);
                lut_disc = fraca_lt_fracb_i ? 4'b0010 : 4'b0001;
            end
        endcase
    end

    // Handshakes and datapath strobes; flush masks every strobe in its cycle.
    always_comb begin
        start_ready_o  = (state_q == StIdle);
        accept         = start_valid_i & start_ready_o & ~flush_i;
        iter_start_o   = accept;
        iter_vld_o     = (state_q == StIter) & ~flush_i;
        iter_end_o     = iter_vld_o & (cnt_q == last_q);
        iter_counter_o = cnt_q;
        quot_bits_calculated_o = '0;
        if (iter_vld_o) begin
            quot_bits_calculated_o = CNT_W'(FIRST_BITS) + cnt_q * CNT_W'(ITER_BITS);
        end
        quot_discard_num_one_hot_o = iter_end_o ? disc_q : 4'b0000;
        post_vld_o     = (state_q == StPost) & ~flush_i;
        finish_valid_o = (state_q == StDone) & ~flush_i;
        finish_hs      = finish_valid_o & finish_ready_i;
    end

    // Next-state logic: flush has priority over every handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        disc_d  = disc_q;
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d = special_case_i ? StPost : StIter;
                        cnt_d   = '0;
                        last_d  = lut_last;
                        disc_d  = lut_disc;
                    end
                end
                StIter: begin
                    if (cnt_q == last_q) begin
                        state_d = StPost;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StPost: state_d = StDone;
                StDone: begin
                    if (finish_hs) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counter and latched lookup registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            disc_q  <= disc_d;
        end
    end

`ifdef FDIV_SRT_ITER_CTRL_PERF_EN
    logic [31:0] perf_ops_q, perf_cycles_q;

    // Completed-operation and busy-cycle counters; flush leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q    <= '0;
            perf_cycles_q <= '0;
        end else begin
            if (finish_hs) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (state_q != StIdle) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
        end
    end

    assign perf_ops_o    = perf_ops_q;
    assign perf_cycles_o = perf_cycles_q;
`endif

endmodule

// File: tb/tb_fdiv_srt_iter_ctrl.sv
// Self-checking bench for fdiv_srt_iter_ctrl: directed scenarios followed by
// randomized operations, checked against a per-operation schedule model.
module tb_fdiv_srt_iter_ctrl;

    localparam int unsigned CNT_W = 6;
    localparam int FIRST = 3;
    localparam int ITER  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_valid_i = 1'b0;
    logic             start_ready_o;
    logic [1:0]       fp_format_i = 2'd0;
    logic             fraca_lt_fracb_i = 1'b0;
    logic             special_case_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             iter_start_o;
    logic             iter_vld_o;
    logic             iter_end_o;
    logic [CNT_W-1:0] iter_counter_o;
    logic [CNT_W-1:0] quot_bits_calculated_o;
    logic [3:0]       disc_o;
    logic             post_vld_o;
    logic             finish_valid_o;
    logic             finish_ready_i = 1'b0;
`ifdef FDIV_SRT_ITER_CTRL_PERF_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_cycles;
    int unsigned      exp_ops = 0;
    int unsigned      exp_cycles = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fdiv_srt_iter_ctrl #(
        .CNT_W      (CNT_W),
        .FIRST_BITS (FIRST),
        .ITER_BITS  (ITER)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .start_valid_i              (start_valid_i),
        .start_ready_o              (start_ready_o),
        .fp_format_i                (fp_format_i),
        .fraca_lt_fracb_i           (fraca_lt_fracb_i),
        .special_case_i             (special_case_i),
        .flush_i                    (flush_i),
        .iter_start_o               (iter_start_o),
        .iter_vld_o                 (iter_vld_o),
        .iter_end_o                 (iter_end_o),
        .iter_counter_o             (iter_counter_o),
        .quot_bits_calculated_o     (quot_bits_calculated_o),
        .quot_discard_num_one_hot_o (disc_o),
        .post_vld_o                 (post_vld_o),
        .finish_valid_o             (finish_valid_o),
        .finish_ready_i             (finish_ready_i)
`ifdef FDIV_SRT_ITER_CTRL_PERF_EN
        ,
        .perf_ops_o                 (perf_ops),
        .perf_cycles_o              (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Iteration count K and discard amount from the required quotient width.
    function automatic void plan(input logic [1:0] fmt, input bit lt,
                                 output int k, output int disc);
        int m;
        int n;
        m = (fmt == 2'd0) ? 11 : (fmt == 2'd1) ? 24 : 53;
        n = m + 1 + (lt ? 0 : 1);
        k = 1;
        while (FIRST + ITER * (k - 1) < n) k++;
        disc = FIRST + ITER * (k - 1) - n;
    endfunction

    task automatic check_perf();
`ifdef FDIV_SRT_ITER_CTRL_PERF_EN
        check("perf_ops", perf_ops, exp_ops);
        check("perf_cycles", perf_cycles, exp_cycles);
`endif
    endtask

    // One operation, entered and left at posedge+1 with the DUT idle.
    // flush_at: cycle offset after acceptance to flush (0 = never).
    task automatic run_op(input logic [1:0] fmt, input bit lt, input bit sp, input int hold,
                          input int flush_at, input bit after_clear, output bit flushed);
        int k;
        int disc;
        int t;
        int dstart;
        bit done;
        plan(fmt, lt, k, disc);
        dstart  = sp ? 2 : k + 2;
        flushed = 1'b0;
        start_valid_i    = 1'b1;
        fp_format_i      = fmt;
        fraca_lt_fracb_i = lt;
        special_case_i   = sp;
        flush_i          = 1'b0;
        finish_ready_i   = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle_ready", 32'(start_ready_o), 32'd1);
        check("iter_start", 32'(iter_start_o), 32'd1);
        check("idle_strobes", 32'({iter_vld_o, iter_end_o, post_vld_o, finish_valid_o}), 32'd0);
        if (after_clear) check("cnt_cleared", 32'(iter_counter_o), 32'd0);
        @(posedge clk);
        #1;
        done = 1'b0;
        t = 1;
        while (!done) begin
            bit iter_ph;
            bit post_ph;
            bit done_ph;
            bit last;
            int idx;
            iter_ph = !sp && (t <= k);
            post_ph = sp ? (t == 1) : (t == k + 1);
            done_ph = !iter_ph && !post_ph;
            idx     = t - 1;
            last    = iter_ph && (idx == k - 1);
            // Scramble operand qualifiers: the DUT must rely on its latched copy.
            fp_format_i      = 2'($urandom_range(0, 3));
            fraca_lt_fracb_i = 1'($urandom_range(0, 1));
            special_case_i   = 1'($urandom_range(0, 1));
            start_valid_i    = 1'($urandom_range(0, 1));
            flush_i          = (t == flush_at);
            finish_ready_i   = done_ph ? (t >= dstart + hold) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (flush_i) begin
                check("flush_strobes",
                      32'({iter_vld_o, iter_end_o, post_vld_o, finish_valid_o}), 32'd0);
                check("flush_no_start", 32'(iter_start_o), 32'd0);
                done    = 1'b1;
                flushed = 1'b1;
            end else begin
                check("busy_ready", 32'(start_ready_o), 32'd0);
                check("busy_no_start", 32'(iter_start_o), 32'd0);
                check("iter_vld", 32'(iter_vld_o), 32'(iter_ph));
                check("iter_end", 32'(iter_end_o), 32'(last));
                if (iter_ph) begin
                    check("iter_cnt", 32'(iter_counter_o), 32'(idx));
                    check("quot_bits", 32'(quot_bits_calculated_o), 32'(FIRST + ITER * idx));
                end
                check("discard", 32'(disc_o), last ? (32'd1 << disc) : 32'd0);
                check("post_vld", 32'(post_vld_o), 32'(post_ph));
                check("finish_valid", 32'(finish_valid_o), 32'(done_ph));
                if (done_ph && finish_ready_i) begin
                    done = 1'b1;
`ifdef FDIV_SRT_ITER_CTRL_PERF_EN
                    exp_ops++;
`endif
                end
            end
`ifdef FDIV_SRT_ITER_CTRL_PERF_EN
            exp_cycles++;
`endif
            @(posedge clk);
            #1;
            t++;
            if (!done && t > 64) begin
                check("op_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        start_valid_i  = 1'b0;
        flush_i        = 1'b0;
        finish_ready_i = 1'b0;
        check_perf();
    endtask

    // Asynchronous reset asserted in the middle of an f64 iteration run.
    task automatic reset_mid_iter();
        start_valid_i    = 1'b1;
        fp_format_i      = 2'd2;
        fraca_lt_fracb_i = 1'b0;
        special_case_i   = 1'b0;
        @(posedge clk);
        #1;
        start_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_iter", 32'(iter_vld_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(start_ready_o), 32'd1);
        check("rst_strobes", 32'({iter_vld_o, iter_end_o, post_vld_o, finish_valid_o}), 32'd0);
        check("rst_cnt", 32'(iter_counter_o), 32'd0);
        check("rst_disc", 32'(disc_o), 32'd0);
`ifdef FDIV_SRT_ITER_CTRL_PERF_EN
        exp_ops    = 0;
        exp_cycles = 0;
        check_perf();
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl;
        bit prev_fl;
        #1;
        check("reset_ready", 32'(start_ready_o), 32'd1);
        check("reset_strobes",
              32'({iter_start_o, iter_vld_o, iter_end_o, post_vld_o, finish_valid_o}), 32'd0);
        check("reset_cnt", 32'(iter_counter_o), 32'd0);
        check("reset_bits", 32'(quot_bits_calculated_o), 32'd0);
        check("reset_disc", 32'(disc_o), 32'd0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(2'd2, 1'b0, 1'b0, 0, 0, 1'b1, fl);  // f64, lt=0
        run_op(2'd0, 1'b1, 1'b0, 0, 0, 1'b0, fl);  // f16, lt=1
        run_op(2'd1, 1'b0, 1'b0, 0, 0, 1'b0, fl);  // f32, lt=0
        run_op(2'd3, 1'b1, 1'b0, 2, 0, 1'b0, fl);  // reserved behaves as f64
        run_op(2'd1, 1'b1, 1'b1, 0, 0, 1'b0, fl);  // special case
        run_op(2'd0, 1'b0, 1'b0, 5, 0, 1'b0, fl);  // finish held 5 cycles
        run_op(2'd2, 1'b0, 1'b0, 0, 7, 1'b0, fl);  // flush at iteration 6
        run_op(2'd1, 1'b0, 1'b0, 0, 0, fl, fl);    // immediate f32 after flush
        reset_mid_iter();
        run_op(2'd1, 1'b1, 1'b0, 1, 0, 1'b1, fl);
        run_op(2'd0, 1'b0, 1'b1, 0, 0, 1'b0, fl);

        prev_fl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] fmt;
            bit         lt;
            bit         sp;
            int         hold;
            int         fat;
            fmt  = 2'($urandom_range(0, 3));
            lt   = 1'($urandom_range(0, 1));
            sp   = ($urandom_range(0, 3) == 0);
            hold = int'($urandom_range(0, 6));
            fat  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0;
            run_op(fmt, lt, sp, hold, fat, prev_fl, fl);
            prev_fl = fl;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
